// File: rtl/step_pulse_gen_if.sv
// Command and status bundle between the packet executor and the step pulse generator.
// The executor drives the command side; the generator drives step/dir and status.
interface step_pulse_gen_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 load;
    logic                 abort;
    logic [ACC_WIDTH-1:0] in_velocity;
    logic [31:0]          in_steps;
    logic                 in_dir;
    logic                 step;
    logic                 dir;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 overrun;
    logic [31:0]          steps_left;

    modport master (
        output load, abort, in_velocity, in_steps, in_dir,
        input  step, dir, busy, done, aborted, overrun, steps_left
    );

    modport slave (
        input  load, abort, in_velocity, in_steps, in_dir,
        output step, dir, busy, done, aborted, overrun, steps_left
    );
endinterface

// File: rtl/step_pulse_gen.sv
// DDS-paced step/dir pulse generator for one stepper driver.
// A phase accumulator overflow requests each step; pulse high and low times are enforced.
module step_pulse_gen #(
    parameter int ACC_WIDTH   = 32,
    parameter int PULSE_WIDTH = 10,
    parameter int DIR_SETUP   = 5
) (
    input logic             clk,
    input logic             rst,
    step_pulse_gen_if.slave bus
);

    localparam int CNT_MAX = (PULSE_WIDTH > DIR_SETUP) ? PULSE_WIDTH : DIR_SETUP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, HIGH, LOW} state_t;

    state_t state, next_state;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] velocity_q, velocity_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 overrun_q, overrun_d;
    logic [31:0]          steps_left_q, steps_left_d;

    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 accept;
    logic                 cnt_last;
    logic                 has_left;
    logic                 abort_now;
    logic                 req;

    assign sum       = {1'b0, acc_q} + {1'b0, velocity_q};
    assign carry     = sum[ACC_WIDTH];
    assign accept    = bus.load & ~bus.abort;
    assign cnt_last  = (cnt_q == CNT_W'(1));
    assign has_left  = (steps_left_q != 32'd0);
    assign abort_now = abort_pend_q | bus.abort;
    // A carry arriving in the very cycle LOW ends is as good as a pending request.
    assign req       = pending_q | carry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && (bus.in_steps != 32'd0)) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                if (bus.abort) begin
                    next_state = IDLE;
                end else if (cnt_last) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    next_state = IDLE;
                end else if (carry) begin
                    next_state = HIGH;
                end
            end
            HIGH: begin
                if (cnt_last) begin
                    next_state = LOW;
                end
            end
            LOW: begin
                if (cnt_last) begin
                    if (abort_now || !has_left) begin
                        next_state = IDLE;
                    end else if (req) begin
                        next_state = HIGH;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        acc_d        = acc_q;
        velocity_d   = velocity_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        abort_pend_d = abort_pend_q;
        step_d       = step_q;
        dir_d        = dir_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        overrun_d    = overrun_q;
        steps_left_d = steps_left_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    dir_d        = bus.in_dir;
                    steps_left_d = bus.in_steps;
                    velocity_d   = bus.in_velocity;
                    acc_d        = '0;
                    pending_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    aborted_d    = 1'b0;
                    overrun_d    = 1'b0;
                    cnt_d        = CNT_W'(DIR_SETUP);
                    busy_d       = (bus.in_steps != 32'd0);
                    done_d       = (bus.in_steps == 32'd0);
                end
            end
            SETUP: begin
                if (bus.abort) begin
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    busy_d    = 1'b0;
                end else if (!cnt_last) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (bus.abort) begin
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    acc_d = sum[ACC_WIDTH-1:0];
                    if (carry) begin
                        step_d       = 1'b1;
                        steps_left_d = steps_left_q - 32'd1;
                        cnt_d        = CNT_W'(PULSE_WIDTH);
                    end
                end
            end
            HIGH: begin
                acc_d = sum[ACC_WIDTH-1:0];
                if (carry && has_left) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (bus.abort) abort_pend_d = 1'b1;
                if (cnt_last) begin
                    step_d = 1'b0;
                    cnt_d  = CNT_W'(PULSE_WIDTH);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                acc_d = sum[ACC_WIDTH-1:0];
                if (!cnt_last) begin
                    if (carry && has_left) begin
                        if (pending_q) overrun_d = 1'b1;
                        else           pending_d = 1'b1;
                    end
                    if (bus.abort) abort_pend_d = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (abort_now || !has_left) begin
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    aborted_d    = abort_now;
                    pending_d    = 1'b0;
                    abort_pend_d = 1'b0;
                end else if (req) begin
                    // Keep one request queued when a new carry lands on a consumed pending.
                    step_d       = 1'b1;
                    steps_left_d = steps_left_q - 32'd1;
                    cnt_d        = CNT_W'(PULSE_WIDTH);
                    pending_d    = pending_q & carry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            velocity_q   <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            overrun_q    <= 1'b0;
            steps_left_q <= 32'd0;
        end else begin
            acc_q        <= acc_d;
            velocity_q   <= velocity_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            abort_pend_q <= abort_pend_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            overrun_q    <= overrun_d;
            steps_left_q <= steps_left_d;
        end
    end

    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.overrun    = overrun_q;
    assign bus.steps_left = steps_left_q;

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Downstream consumer of the packet executor's register and strobe outputs.
- Turns a loaded motion command (rate, step count, direction) into step/dir pulses for one stepper driver on the j-header pins.
- Rate is produced by a phase-accumulator (DDS) overflow.
- Completion is reported as a one-cycle done strobe, wired back to an executor interrupt input.

Parameters:
- ACC_WIDTH, 32: accumulator and velocity width.
- PULSE_WIDTH, 10: step high time in clk cycles; minimum low time is the same value (min 1).
- DIR_SETUP, 5: cycles between a dir update and the first accumulation (min 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- load  in  1  one-cycle strobe; latches in_velocity, in_steps, in_dir.
- abort  in  1  one-cycle strobe; stops the move after the current pulse.
- in_velocity  in  ACC_WIDTH  unsigned increment added per clk in RUN.
- in_steps  in  32  number of step pulses to emit.
- in_dir  in  1  direction level for this move.
- step  out  1  step pulse to driver.
- dir  out  1  direction to driver.
- busy  out  1  high from the cycle after an accepted load until done.
- done  out  1  one-cycle strobe at move end (normal, abort, or zero steps).
- aborted  out  1  sticky: last move ended by abort; cleared on accepted load.
- overrun  out  1  sticky: a step request was lost; cleared on accepted load.
- steps_left  out  32  remaining steps; decrements on each step rising edge.

Behaviour:
- Reset values (rst low, asynchronous): state IDLE; step=0, dir=0, busy=0, done=0, aborted=0, overrun=0, steps_left=0; acc=0, pending=0.
- States: IDLE, SETUP, RUN, HIGH, LOW.
- IDLE:
  - load=1 and abort=0 → latch inputs; dir<=in_dir, steps_left<=in_steps, acc<=0; clear aborted and overrun; busy<=1.
  - If in_steps=0: go to IDLE again and pulse done next cycle; no step is emitted.
  - Otherwise go to SETUP with setup counter = DIR_SETUP.
  - load and abort together in IDLE: abort wins; load is ignored and no done is issued.
- SETUP: hold for DIR_SETUP cycles, then RUN. Abort here → IDLE, done=1, aborted=1, with no step emitted.
- RUN:
  - Each cycle: {carry, acc} <= acc + velocity, using ACC_WIDTH+1-bit addition with the carry dropped from acc.
  - carry=1 → step<=1, steps_left<=steps_left-1, go to HIGH.
  - velocity=0 means it waits forever; only abort exits.
- HIGH: step held 1 for exactly PULSE_WIDTH cycles, then step<=0 and go to LOW.
- LOW:
  - Hold step 0 for at least PULSE_WIDTH cycles.
  - At the end: if steps_left=0 → IDLE with done=1 and busy<=0.
  - Else if pending → clear pending, emit the next step immediately (step<=1, decrement, go to HIGH).
  - Else → RUN.
- Accumulation continues in HIGH and LOW so rate is preserved.
  - A carry there sets pending.
  - A carry while pending is already 1 sets overrun; that request is dropped.
  - No carries are counted once steps_left=0.
- Abort in RUN → IDLE next cycle: done=1, aborted=1, busy=0.
- Abort in HIGH/LOW is latched. The pulse is never truncated: HIGH and the full LOW complete, then go to IDLE with done=1 and aborted=1.
- load while busy is ignored; latched values are unchanged.
- done is asserted only in the single cycle after the terminating transition. busy falls in that same cycle.
- dir changes only on an accepted load, and never while step=1.
- Reset asserted mid-move: step drops immediately (async); no done is issued.

Test Plan:
- Reset: rst=0 mid-HIGH → step=0, busy=0, steps_left=0 immediately. After release, all outputs stay idle.
- Normal move: velocity=2^26 (carry every 64 cycles), steps=3, dir=1:
  - dir=1 one cycle after load; first step rise 5+64 cycles after load.
  - Exactly 3 pulses, each high 10 cycles, spaced 64 cycles.
  - steps_left goes 3→0; one done pulse; busy low; overrun=0.
- Zero steps: load with steps=0 → done exactly once the cycle after the accept, no step, busy never sticks.
- Overrun: velocity=2^30 (carry every 4 cycles), steps=5:
  - Pulses spaced the 20-cycle minimum period.
  - overrun=1 by the second pulse.
  - Still exactly 5 pulses, then done.
- Abort in HIGH: abort 3 cycles into pulse 2 of 10 → pulse 2 stays high the full 10 cycles, LOW completes, then done=1, aborted=1, steps_left=8.
- Ignored inputs: load with in_dir=0 during a busy move → dir unchanged and the move finishes with its original count. Simultaneous load+abort in IDLE → no activity, no done.
